clk_div_multi: RTL and testbench

Parametrised multi-channel programmable clock divider. It is the successor to the fixed single-output 50 MHz→1 Hz divider. It provides NCH independent channels, each with a runtime-loadable divisor, a per-channel square/pulse mode, enable, and a global synchronous restart for phase alignment. It sits next to the board clock and feeds slow clocks and tick strobes to the controller, display-scan and debounce logic.

---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_chan.sv | 90 +++++++++
 rtl/clk_div_multi.sv | 48 ++++
 tb/tb_clk_div_multi.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the multi-channel programmable clock divider.
package clk_div_pkg;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_t;

    // 1 Hz square output from a 50 MHz board clock.
    localparam int unsigned DEFAULT_DIV_C = 25000000;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: up-counter, active/shadow divisor, mode and registered outputs.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int          W           = 26,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_C
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         wr,
    input  logic [W-1:0] wr_div,
    input  logic         wr_mode,
    input  logic         restart,
    output logic         clk_out,
    output logic         tick
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] div_a_q, div_a_d;
    logic [W-1:0] div_s_q, div_s_d;
    logic         pend_q, pend_d;
    mode_t        mode_q, mode_d;
    logic         clk_q, clk_d;
    logic         tick_q, tick_d;

    logic         pend_nxt;
    logic         at_tc;

    always_comb begin
        cnt_d    = cnt_q;
        div_a_d  = div_a_q;
        clk_d    = clk_q;
        tick_d   = 1'b0;
        // A write reshapes the output from this very cycle on.
        mode_d   = wr ? mode_t'(wr_mode) : mode_q;
        div_s_d  = wr ? wr_div : div_s_q;
        pend_nxt = pend_q | wr;
        pend_d   = pend_nxt;
        at_tc    = (cnt_q >= div_a_q - W'(1));

        if (restart) begin
            cnt_d   = '0;
            clk_d   = 1'b0;
            div_a_d = pend_nxt ? div_s_d : div_a_q;
            pend_d  = 1'b0;
        end else if (div_a_q == '0) begin
            cnt_d   = '0;
            clk_d   = 1'b0;
            div_a_d = pend_nxt ? div_s_d : div_a_q;
            pend_d  = 1'b0;
        end else if (!en) begin
            clk_d = (mode_d == MODE_PULSE) ? 1'b0 : clk_q;
        end else if (at_tc) begin
            cnt_d   = '0;
            tick_d  = 1'b1;
            clk_d   = (mode_d == MODE_PULSE) ? 1'b1 : ~clk_q;
            // Divisor swaps only on a period boundary, so no period is truncated.
            div_a_d = pend_nxt ? div_s_d : div_a_q;
            pend_d  = 1'b0;
        end else begin
            cnt_d = cnt_q + W'(1);
            clk_d = (mode_d == MODE_PULSE) ? 1'b0 : clk_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            div_a_q <= W'(DEFAULT_DIV);
            div_s_q <= W'(DEFAULT_DIV);
            pend_q  <= 1'b0;
            mode_q  <= MODE_SQUARE;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_a_q <= div_a_d;
            div_s_q <= div_s_d;
            pend_q  <= pend_d;
            mode_q  <= mode_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// NCH independent programmable dividers with per-channel write decode and shared restart.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int          NCH         = 4,
    parameter int          W           = 26,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_C
) (
    input  logic                       CLK_50M,
    input  logic                       nCLR,
    input  logic [NCH-1:0]             en,
    input  logic                       wr_en,
    input  logic [ch_width(NCH)-1:0]   wr_ch,
    input  logic [W-1:0]               wr_div,
    input  logic                       wr_mode,
    input  logic                       restart,
    output logic [NCH-1:0]             CLK_Out,
    output logic [NCH-1:0]             Tick
);

    logic [NCH-1:0] wr_sel;

    // Addresses at or beyond NCH match no channel and are dropped.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_sel[i] = wr_en && (int'(wr_ch) == i);
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clk_div_chan #(
            .W           (W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk     (CLK_50M),
            .rst_n   (nCLR),
            .en      (en[g]),
            .wr      (wr_sel[g]),
            .wr_div  (wr_div),
            .wr_mode (wr_mode),
            .restart (restart),
            .clk_out (CLK_Out[g]),
            .tick    (Tick[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomised and directed bench for clk_div_multi against a countdown reference model.
module tb_clk_div_multi;

    localparam int NCH = 3;
    localparam int W   = 8;
    localparam int DEF = 5;

    logic           CLK_50M = 1'b0;
    logic           nCLR = 1'b0;
    logic [NCH-1:0] en = '0;
    logic           wr_en = 1'b0;
    logic [1:0]     wr_ch = '0;
    logic [W-1:0]   wr_div = '0;
    logic           wr_mode = 1'b0;
    logic           restart = 1'b0;
    logic [NCH-1:0] CLK_Out;
    logic [NCH-1:0] Tick;

    int n_vec = 0;
    int n_err = 0;

    clk_div_multi #(
        .NCH         (NCH),
        .W           (W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .CLK_50M (CLK_50M),
        .nCLR    (nCLR),
        .en      (en),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .wr_mode (wr_mode),
        .restart (restart),
        .CLK_Out (CLK_Out),
        .Tick    (Tick)
    );

    always #5 CLK_50M = ~CLK_50M;

    // Reference model: each channel counts down the cycles left until its terminal count.
    int m_div[NCH], m_sh[NCH], m_pend[NCH], m_mode[NCH], m_left[NCH], m_clk[NCH], m_tick[NCH];

    always @(posedge CLK_50M or negedge nCLR) begin
        if (!nCLR) begin
            for (int i = 0; i < NCH; i++) begin
                m_div[i] = DEF; m_sh[i] = DEF; m_pend[i] = 0; m_mode[i] = 0;
                m_left[i] = DEF; m_clk[i] = 0; m_tick[i] = 0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                bit w;
                w = wr_en && (int'(wr_ch) == i);
                if (w) begin
                    m_sh[i] = int'(wr_div); m_mode[i] = int'(wr_mode); m_pend[i] = 1;
                end
                m_tick[i] = 0;
                if (restart || m_div[i] == 0) begin
                    if (m_pend[i] != 0) m_div[i] = m_sh[i];
                    m_pend[i] = 0;
                    m_left[i] = m_div[i];
                    m_clk[i]  = 0;
                end else if (!en[i]) begin
                    if (m_mode[i] == 1) m_clk[i] = 0;
                end else begin
                    m_left[i] = m_left[i] - 1;
                    if (m_left[i] == 0) begin
                        m_tick[i] = 1;
                        m_clk[i]  = (m_mode[i] == 1) ? 1 : 1 - m_clk[i];
                        if (m_pend[i] != 0) m_div[i] = m_sh[i];
                        m_pend[i] = 0;
                        m_left[i] = m_div[i];
                    end else if (m_mode[i] == 1) begin
                        m_clk[i] = 0;
                    end
                end
            end
        end
    end

    // Scoreboard compare: every cycle out of reset, DUT outputs against the model.
    always @(negedge CLK_50M) begin
        if (nCLR) begin
            logic [NCH-1:0] exp_clk, exp_tick;
            for (int i = 0; i < NCH; i++) begin
                exp_clk[i]  = (m_clk[i] != 0);
                exp_tick[i] = (m_tick[i] != 0);
            end
            n_vec++;
            if (CLK_Out !== exp_clk || Tick !== exp_tick) begin
                n_err++;
                $display("FAIL model_cmp t=%0t CLK_Out=%b exp %b Tick=%b exp %b",
                         $time, CLK_Out, exp_clk, Tick, exp_tick);
            end
        end
    end

    task automatic pin(input string name, input logic [NCH-1:0] act,
                       input logic [NCH-1:0] mask, input logic [NCH-1:0] exp);
        n_vec++;
        if ((act & mask) !== (exp & mask)) begin
            n_err++;
            $display("FAIL %s t=%0t got %b expected %b (mask %b)", name, $time, act, exp, mask);
        end
    endtask

    task automatic do_write(input int ch, input int div, input int mode);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_div  = W'(div);
        wr_mode = mode[0];
        @(negedge CLK_50M);
        wr_en = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK_50M);
    endtask

    initial begin
        cyc(3);
        pin("reset_clk", CLK_Out, '1, '0);
        pin("reset_tick", Tick, '1, '0);

        // Release with all channels enabled: first TC on the 5th edge.
        en   = '1;
        nCLR = 1'b1;
        cyc(4);
        pin("pre_tc_tick", Tick, '1, '0);
        cyc(1);
        pin("first_tc_tick", Tick, '1, 3'b111);
        pin("first_tc_clk", CLK_Out, '1, 3'b111);
        cyc(5);
        pin("second_tc_clk", CLK_Out, '1, 3'b000);
        pin("second_tc_tick", Tick, '1, 3'b111);

        // Write div=3 pulse to ch1 at count 2; old period still ends at edge 15.
        cyc(2);
        do_write(1, 3, 1);
        cyc(2);
        pin("old_period_tick1", Tick, 3'b010, 3'b010);
        pin("old_period_clk", CLK_Out, 3'b011, 3'b011);
        cyc(2);
        pin("pulse_low_clk1", CLK_Out, 3'b010, 3'b000);
        cyc(1);
        pin("pulse_high_clk1", CLK_Out, 3'b010, 3'b010);

        // Halt ch0, then restart it with div=1; an out-of-range address is ignored.
        do_write(0, 0, 0);
        cyc(12);
        pin("halted_ch0", CLK_Out | Tick, 3'b001, 3'b000);
        do_write(3, 2, 1);
        cyc(3);
        do_write(0, 1, 0);
        cyc(8);

        // Phase alignment: ch0=4, ch1=6, then restart.
        do_write(0, 4, 0);
        do_write(1, 6, 0);
        restart = 1'b1;
        cyc(1);
        restart = 1'b0;
        pin("restart_clk", CLK_Out, '1, '0);
        pin("restart_tick", Tick, '1, '0);
        cyc(4);
        pin("ch0_tc_at_4", Tick, 3'b011, 3'b001);
        cyc(2);
        pin("ch1_tc_at_6", Tick, 3'b011, 3'b010);
        cyc(6);
        pin("aligned_tick_12", Tick, 3'b011, 3'b011);
        pin("aligned_clk_12", CLK_Out, 3'b011, 3'b001);

        // Stall ch0 for 7 cycles mid-count.
        cyc(2);
        en[0] = 1'b0;
        cyc(7);
        en[0] = 1'b1;
        cyc(20);

        // Asynchronous reset between edges.
        @(posedge CLK_50M);
        #2 nCLR = 1'b0;
        #1 pin("async_clk", CLK_Out, '1, '0);
        pin("async_tick", Tick, '1, '0);
        @(negedge CLK_50M);
        en   = '1;
        nCLR = 1'b1;
        cyc(5);
        pin("default_div_restored", Tick, '1, 3'b111);

        // Randomised traffic.
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < NCH; i++) en[i] = ($urandom_range(0, 7) != 0);
            wr_en   = ($urandom_range(0, 9) == 0);
            wr_ch   = 2'($urandom_range(0, 3));
            wr_div  = ($urandom_range(0, 15) == 0) ? W'(255) : W'($urandom_range(0, 7));
            wr_mode = 1'($urandom_range(0, 1));
            restart = ($urandom_range(0, 49) == 0);
            cyc(1);
        end
        wr_en   = 1'b0;
        restart = 1'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
